// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and helpers for the Trivium keystream core.
// Taps use the 1-based state numbering s[1..288] of the cipher description.
package trivium_pkg;

  localparam int KEY_BYTES = 10;
  localparam int IV_BYTES  = 10;
  localparam int STATE_W   = 288;
  localparam int IV_OFS    = 93;

  localparam int T1_A  = 66;
  localparam int T1_B  = 93;
  localparam int T2_A  = 162;
  localparam int T2_B  = 177;
  localparam int T3_A  = 243;
  localparam int T3_B  = 288;
  localparam int T1_N0 = 91;
  localparam int T1_N1 = 92;
  localparam int T1_FB = 171;
  localparam int T2_N0 = 175;
  localparam int T2_N1 = 176;
  localparam int T2_FB = 264;
  localparam int T3_N0 = 286;
  localparam int T3_N1 = 287;
  localparam int T3_FB = 69;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // Key byte i lands at s[8i+1..8i+8]; IV byte i at s[94+8(i-10)..].
  function automatic logic [STATE_W:1] load_byte(
    input logic [STATE_W:1] s,
    input logic [4:0]       idx,
    input logic [7:0]       d
  );
    logic [STATE_W:1] r;
    int base;
    r = s;
    if (int'(idx) < KEY_BYTES)
      base = 8 * int'(idx) + 1;
    else
      base = IV_OFS + 8 * (int'(idx) - KEY_BYTES) + 1;
    r[base +: 8] = d;
    return r;
  endfunction

endpackage

// File: rtl/trivium_step.sv
// One combinational Trivium round: s_i -> s_o, with keystream bit z_o.
// Ports: s_i (state in, s[288:1]), s_o (state out), z_o (output bit).
module trivium_step
  import trivium_pkg::*;
(
  input  logic [STATE_W:1] s_i,
  output logic [STATE_W:1] s_o,
  output logic             z_o
);

  logic t1, t2, t3;
  logic n1, n2, n3;

  assign t1  = s_i[T1_A] ^ s_i[T1_B];
  assign t2  = s_i[T2_A] ^ s_i[T2_B];
  assign t3  = s_i[T3_A] ^ s_i[T3_B];
  assign z_o = t1 ^ t2 ^ t3;

  assign n1 = t1 ^ (s_i[T1_N0] & s_i[T1_N1]) ^ s_i[T1_FB];
  assign n2 = t2 ^ (s_i[T2_N0] & s_i[T2_N1]) ^ s_i[T2_FB];
  assign n3 = t3 ^ (s_i[T3_N0] & s_i[T3_N1]) ^ s_i[T3_FB];

  // Three shift registers: n3 enters s1, n1 enters s94, n2 enters s178.
  assign s_o = {s_i[287:178], n2,
                s_i[176:94],  n1,
                s_i[92:1],    n3};

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator, WORD_W bits/cycle, byte-serial key/IV load,
// self-timed warm-up, registered keystream output with valid/ready stall.
// Ports: clk, rst_n, ena, rekey, load_valid/load_data/load_ready,
//   ks_valid/ks_ready/ks_data, busy; pt_data only with TRIVIUM_ENCRYPT_EN
//   (output register then holds pt_data ^ keystream).
module trivium_keystream_gen
  import trivium_pkg::*;
#(
  parameter int WORD_W        = 8,
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rekey,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [WORD_W-1:0] ks_data,
  output logic              busy
`ifdef TRIVIUM_ENCRYPT_EN
  ,
  input  logic [WORD_W-1:0] pt_data
`endif
);

  localparam int WARM_CYC = WARMUP_ROUNDS / WORD_W;
  localparam int CNT_W    = $clog2(WARM_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WARM_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       LAST_BYTE =
    5'(KEY_BYTES + IV_BYTES - 1);

  state_e              st_q, st_d;
  logic [4:0]          byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]    warm_q, warm_d;
  logic [STATE_W:1]    s_q, s_d;
  logic                vld_q, vld_d;
  logic [WORD_W-1:0]   ks_q, ks_d;

  logic                ks_hs;
  logic                last_byte;
  logic [STATE_W:1]    ld_s;
  logic [STATE_W:1]    chain_in;
  logic [STATE_W:1]    chain_out;
  logic [WORD_W-1:0]   z_w;
  logic [WORD_W-1:0]   pt_w;

`ifdef TRIVIUM_ENCRYPT_EN
  assign pt_w = pt_data;
`else
  assign pt_w = '0;
`endif

  assign load_ready = ena && (st_q == ST_LOAD);
  assign ks_hs      = ena && vld_q && ks_ready;
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign busy       = (st_q == ST_WARMUP);
  assign ks_valid   = vld_q;
  assign ks_data    = ks_q;

  always_comb begin
    ld_s = load_byte(s_q, byte_cnt_q, load_data);
    if (last_byte)
      ld_s[STATE_W:STATE_W-2] = 3'b111;
  end

  // The last load edge already runs one word of warm-up rounds, so the
  // final warm-up cycle can register the first keystream word directly.
  assign chain_in = (st_q == ST_LOAD) ? ld_s : s_q;

  for (genvar k = 0; k < WORD_W; k++) begin : g_st
    logic [STATE_W:1] s_in;
    logic [STATE_W:1] s_out;
    if (k == 0) begin : g_first
      assign s_in = chain_in;
    end else begin : g_next
      assign s_in = g_st[k-1].s_out;
    end
    trivium_step u_step (
      .s_i (s_in),
      .s_o (s_out),
      .z_o (z_w[k])
    );
  end

  assign chain_out = g_st[WORD_W-1].s_out;

  always_comb begin
    st_d       = st_q;
    byte_cnt_d = byte_cnt_q;
    warm_d     = warm_q;
    s_d        = s_q;
    vld_d      = vld_q;
    ks_d       = ks_q;
    if (ena) begin
      if (rekey) begin
        st_d       = ST_LOAD;
        byte_cnt_d = '0;
        warm_d     = '0;
        s_d        = '0;
        vld_d      = 1'b0;
        ks_d       = '0;
      end else begin
        unique case (st_q)
          ST_LOAD: begin
            if (load_valid) begin
              if (last_byte) begin
                s_d        = chain_out;
                st_d       = ST_WARMUP;
                warm_d     = CNT_ONE;
                byte_cnt_d = '0;
              end else begin
                s_d        = ld_s;
                byte_cnt_d = byte_cnt_q + 5'd1;
              end
            end
          end
          ST_WARMUP: begin
            s_d = chain_out;
            if (warm_q == CNT_LAST) begin
              st_d   = ST_RUN;
              warm_d = '0;
              vld_d  = 1'b1;
              ks_d   = z_w ^ pt_w;
            end else begin
              warm_d = warm_q + CNT_ONE;
            end
          end
          ST_RUN: begin
            if (ks_hs) begin
              s_d  = chain_out;
              ks_d = z_w ^ pt_w;
            end
          end
          default: st_d = ST_LOAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_LOAD;
      byte_cnt_q <= '0;
      warm_q     <= '0;
      s_q        <= '0;
      vld_q      <= 1'b0;
      ks_q       <= '0;
    end else begin
      st_q       <= st_d;
      byte_cnt_q <= byte_cnt_d;
      warm_q     <= warm_d;
      s_q        <= s_d;
      vld_q      <= vld_d;
      ks_q       <= ks_d;
    end
  end

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Scoreboard bench for trivium_keystream_gen (WORD_W=8, full warm-up).
// Golden model uses the three-register A/B/C form of Trivium.
module tb_trivium_keystream_gen;

  localparam int WW = 8;
  localparam int WR = 1152;
  localparam int NW = WR / WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          rekey = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = '0;
  logic          load_ready;
  logic          ks_valid;
  logic          ks_ready = 1'b0;
  logic [WW-1:0] ks_data;
  logic          busy;

  always #5 clk = ~clk;

  trivium_keystream_gen #(
    .WORD_W        (WW),
    .WARMUP_ROUNDS (WR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rekey      (rekey),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  bit ma [1:93];
  bit mb [1:84];
  bit mc [1:111];

  function automatic bit m_bit();
    bit t1, t2, t3, z;
    t1 = ma[66] ^ ma[93];
    t2 = mb[69] ^ mb[84];
    t3 = mc[66] ^ mc[111];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ma[91] & ma[92]) ^ mb[78];
    t2 = t2 ^ (mb[82] & mb[83]) ^ mc[87];
    t3 = t3 ^ (mc[109] & mc[110]) ^ ma[69];
    for (int n = 93; n > 1; n--) ma[n] = ma[n-1];
    for (int n = 84; n > 1; n--) mb[n] = mb[n-1];
    for (int n = 111; n > 1; n--) mc[n] = mc[n-1];
    ma[1] = t3;
    mb[1] = t1;
    mc[1] = t2;
    return z;
  endfunction

  function automatic logic [WW-1:0] m_word();
    logic [WW-1:0] w;
    for (int k = 0; k < WW; k++) w[k] = m_bit();
    return w;
  endfunction

  task automatic m_init(input logic [79:0] k, input logic [79:0] iv);
    for (int n = 1; n <= 93; n++) ma[n] = 1'b0;
    for (int n = 1; n <= 84; n++) mb[n] = 1'b0;
    for (int n = 1; n <= 111; n++) mc[n] = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      ma[n] = k[n-1];
      mb[n] = iv[n-1];
    end
    mc[109] = 1'b1;
    mc[110] = 1'b1;
    mc[111] = 1'b1;
    for (int r = 0; r < WR; r++) void'(m_bit());
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(m_word());
  endtask

  // Monitor: pops on every handshake, checks data hold while stalled.
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'(ks_data), 64'(prev_data));
      if (ena && ks_valid && ks_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ks_word got %0h want none", ks_data);
        end else begin
          chk("ks_word", 64'(ks_data), 64'(exp_q.pop_front()));
        end
      end
      prev_stall <= ks_valid && !(ena && ks_ready) && !rekey;
      prev_data  <= ks_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [79:0] k, input logic [79:0] iv);
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = (i < 10) ? k[8*i +: 8] : iv[8*(i-10) +: 8];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Latency in cycles from the cycle of the last accepted byte.
  task automatic wait_valid(input int gap_at, output int lat);
    lat = 1;
    while (!ks_valid && lat < NW + 100) begin
      if (lat == gap_at) begin
        ena = 1'b0;
        repeat (10) tick();
        lat += 10;
        ena = 1'b1;
      end
      tick();
      lat++;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      ks_ready = 1'($urandom_range(0, 1));
      tick();
      b--;
    end
    ks_ready = 1'b0;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [79:0] k1, k2, k3, k4, iv2, iv3, iv4;
    k1  = 80'h80;
    k2  = 80'h0123456789abcdef0123;
    iv2 = 80'hfedcba9876543210aa55;
    k3  = 80'h00ff00ff00ff00ff00ff;
    iv3 = 80'h13579bdf2468ace01122;
    k4  = 80'hdeadbeefcafef00d1234;
    iv4 = 80'h0;

    #12;
    chk("rst_ks_valid", 64'(ks_valid), 64'd0);
    chk("rst_ks_data", 64'(ks_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    m_init(k1, 80'h0);
    push_words(24);
    load_all(k1, 80'h0);
    chk("warm_busy", 64'(busy), 64'd1);
    chk("warm_no_ready", 64'(load_ready), 64'd0);
    wait_valid(-1, lat);
    chk("latency_k1", 64'(lat), 64'(1 + NW));
    drain(800);

    push_words(1);
    ks_ready = 1'b1;
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    ks_ready = 1'b0;
    exp_q.delete();
    chk("rekey_run_ready", 64'(load_ready), 64'd1);
    chk("rekey_run_valid", 64'(ks_valid), 64'd0);
    chk("rekey_run_data", 64'(ks_data), 64'd0);

    load_all(k2, iv2);
    repeat (50) tick();
    chk("pre_rekey_busy", 64'(busy), 64'd1);
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    chk("rekey_warm_busy", 64'(busy), 64'd0);
    chk("rekey_warm_ready", 64'(load_ready), 64'd1);

    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'haa;
      tick();
    end
    load_data = 8'h55;
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    load_valid = 1'b0;

    m_init(k3, iv3);
    push_words(16);
    load_all(k3, iv3);
    wait_valid(-1, lat);
    chk("latency_k3", 64'(lat), 64'(1 + NW));
    drain(600);

    rekey = 1'b1;
    tick();
    rekey = 1'b0;
    m_init(k4, iv4);
    push_words(8);
    load_all(k4, iv4);
    wait_valid(20, lat);
    chk("latency_ena_gap", 64'(lat), 64'(1 + NW + 10));
    drain(400);

    chk("run_valid", 64'(ks_valid), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ks_valid", 64'(ks_valid), 64'd0);
    chk("arst_ks_data", 64'(ks_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_load_ready", 64'(load_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    m_init(k2, iv2);
    push_words(8);
    load_all(k2, iv2);
    wait_valid(-1, lat);
    chk("latency_k2", 64'(lat), 64'(1 + NW));
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
